// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider with start/done handshake, runtime signed/unsigned
// mode, and divide-by-zero / signed-overflow flags.
module seq_div_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_SUB   = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dvs_neg_q, dvs_neg_d;
  logic             ovf_case_q, ovf_case_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  // Magnitudes at WIDTH bits: the most-negative value maps onto 2^(WIDTH-1) unsigned.
  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign trial   = r_q - {1'b0, d_q};

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    sgn_d      = sgn_q;
    dvd_neg_d  = dvd_neg_q;
    dvs_neg_d  = dvs_neg_q;
    ovf_case_d = ovf_case_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            quot_d  = '1;
            rem_d   = dividend;
            state_d = S_DONE;
          end else begin
            dbz_d      = 1'b0;
            ovf_d      = 1'b0;
            cnt_d      = '0;
            sgn_d      = is_signed;
            dvd_neg_d  = is_signed & dividend[WIDTH-1];
            dvs_neg_d  = is_signed & divisor[WIDTH-1];
            ovf_case_d = is_signed && (dividend == MOST_NEG) && (divisor == '1);
            q_d        = dvd_mag;
            d_d        = dvs_mag;
            r_d        = '0;
            state_d    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = S_SUB;
      end
      S_SUB: begin
        if (!trial[WIDTH]) begin
          r_d = trial;
          q_d = {q_q[WIDTH-1:1], 1'b1};
        end
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == LAST_CNT) ? S_FIX : S_SHIFT;
      end
      S_FIX: begin
        if (ovf_case_q) begin
          quot_d = MOST_NEG;
          rem_d  = '0;
          ovf_d  = 1'b1;
        end else begin
          quot_d = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? -q_q : q_q;
          rem_d  = (sgn_q && dvd_neg_q) ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      sgn_q      <= 1'b0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      ovf_case_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      sgn_q      <= sgn_d;
      dvd_neg_q  <= dvd_neg_d;
      dvs_neg_q  <= dvs_neg_d;
      ovf_case_q <= ovf_case_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state     = state_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed vector table, multi-cycle corner sequences and a random sweep for
// seq_div_unit at WIDTH=8 and WIDTH=16.
module tb_seq_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st8 = 0, sgn8 = 0;
  logic [7:0]  dvd8 = 0, dvs8 = 0, q8, r8;
  logic        busy8, done8, dbz8, ovf8;
  logic [2:0]  state8;

  logic        st16 = 0, sgn16 = 0;
  logic [15:0] dvd16 = 0, dvs16 = 0, q16, r16;
  logic        busy16, done16, dbz16, ovf16;
  logic [2:0]  state16;

  seq_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .is_signed(sgn8),
    .dividend(dvd8), .divisor(dvs8), .quotient(q8), .remainder(r8),
    .busy(busy8), .done(done8), .dbz(dbz8), .ovf(ovf8), .state(state8)
  );

  seq_div_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .is_signed(sgn16),
    .dividend(dvd16), .divisor(dvs16), .quotient(q16), .remainder(r16),
    .busy(busy16), .done(done16), .dbz(dbz16), .ovf(ovf16), .state(state16)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: truncating division on sign-extended integers.
  task automatic model(input int w, input bit s, input longint a, input longint b,
                       output longint q, output longint r, output bit dz, output bit ov);
    longint mask, half, sa, sb;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    dz = 0; ov = 0;
    if (b == 0) begin
      dz = 1; q = mask; r = a;
    end else if (s) begin
      sa = (a >= half) ? a - (longint'(1) << w) : a;
      sb = (b >= half) ? b - (longint'(1) << w) : b;
      q  = (sa / sb) & mask;
      r  = (sa % sb) & mask;
      ov = (sa == -half) && (sb == -1);
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  // Issues one division and counts edges (start-sampling edge = 1) until done.
  task automatic run(input int w, input bit s, input longint a, input longint b,
                     output longint q, output longint r, output bit dz, output bit ov,
                     output int lat, output bit pulse_ok, output bit busy_ok);
    if (w == 8) begin sgn8 = s; dvd8 = a[7:0]; dvs8 = b[7:0]; st8 = 1; end
    else begin sgn16 = s; dvd16 = a[15:0]; dvs16 = b[15:0]; st16 = 1; end
    lat = 0; busy_ok = 1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      st8 = 0; st16 = 0;
      if (((w == 8) ? busy8 : busy16) == 1'b0) busy_ok = 0;
      if ((w == 8) ? done8 : done16) begin lat = k; break; end
    end
    q  = (w == 8) ? longint'(q8)  : longint'(q16);
    r  = (w == 8) ? longint'(r8)  : longint'(r16);
    dz = (w == 8) ? dbz8 : dbz16;
    ov = (w == 8) ? ovf8 : ovf16;
    @(posedge clk); #1;
    pulse_ok = !((w == 8) ? done8 : done16);
  endtask

  typedef struct {
    bit         s;
    logic [7:0] a, b, eq, er;
    bit         edz, eov;
    int         elat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    longint q, r, mq, mr;
    bit dz, ov, pulse_ok, busy_ok, mdz, mov;
    int lat, k;

    vecs[0] = '{0, 8'd100, 8'd7,  8'h0E, 8'h02, 0, 0, 18};
    vecs[1] = '{1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 0, 0, 18};
    vecs[2] = '{1, 8'h64,  8'hF9, 8'hF2, 8'h02, 0, 0, 18};
    vecs[3] = '{0, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1, 0, 1};
    vecs[4] = '{1, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1, 0, 1};
    vecs[5] = '{0, 8'd9,   8'd3,  8'h03, 8'h00, 0, 0, 18};
    vecs[6] = '{1, 8'h80,  8'hFF, 8'h80, 8'h00, 0, 1, 18};
    vecs[7] = '{0, 8'h80,  8'hFF, 8'h00, 8'h80, 0, 0, 18};
    vecs[8] = '{0, 8'hFF,  8'h10, 8'h0F, 8'h0F, 0, 0, 18};
    vecs[9] = '{1, 8'h9C,  8'hF9, 8'h0E, 8'hFE, 0, 0, 18};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state8, 0);
    chk("reset_q", q8, 0);
    chk("reset_r", r8, 0);
    chk("reset_flags", {busy8, done8, dbz8, ovf8}, 0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run(8, vecs[i].s, vecs[i].a, vecs[i].b, q, r, dz, ov, lat, pulse_ok, busy_ok);
      $display("vec %0d: s=%0d 0x%02h/0x%02h -> q=0x%02h r=0x%02h dbz=%0d ovf=%0d lat=%0d",
               i, vecs[i].s, vecs[i].a, vecs[i].b, q, r, dz, ov, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
      chk($sformatf("vec%0d_r", i), r, vecs[i].er);
      chk($sformatf("vec%0d_dbz", i), dz, vecs[i].edz);
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].eov);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("vec%0d_pulse", i), pulse_ok, 1);
      chk($sformatf("vec%0d_busy", i), busy_ok, 1);
    end

    // start pulsed mid-operation with new operands must be ignored
    sgn8 = 0; dvd8 = 100; dvs8 = 7; st8 = 1;
    lat = 0;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      st8 = 0;
      if (k == 4) begin st8 = 1; dvd8 = 200; dvs8 = 3; sgn8 = 1; end
      if (k == 5) begin dvd8 = 1; dvs8 = 1; end
      if (done8) begin lat = k; break; end
    end
    $display("busy-start: q=0x%02h r=0x%02h lat=%0d", q8, r8, lat);
    chk("busy_start_q", q8, 8'h0E);
    chk("busy_start_r", r8, 8'h02);
    chk("busy_start_lat", lat, 18);

    // start raised in the DONE cycle is ignored, but held into IDLE it is taken
    sgn8 = 0; dvd8 = 255; dvs8 = 16; st8 = 1;
    @(posedge clk); #1;
    chk("done_start_idle", state8, 0);
    chk("done_start_busy", busy8, 0);
    @(posedge clk); #1;
    st8 = 0;
    chk("held_start_shift", state8, 1);
    lat = 0;
    for (k = 2; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done8) begin lat = k; break; end
    end
    $display("held-start: q=0x%02h r=0x%02h lat=%0d", q8, r8, lat);
    chk("held_start_q", q8, 8'h0F);
    chk("held_start_r", r8, 8'h0F);
    chk("held_start_lat", lat, 18);
    @(posedge clk); #1;

    // asynchronous reset in the middle of SUB
    sgn8 = 0; dvd8 = 100; dvs8 = 7; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    k = 0;
    while (state8 != 3'd2 && k < 20) begin @(posedge clk); #1; k++; end
    chk("reached_sub", state8, 2);
    rst = 1; #1;
    $display("mid-SUB reset: state=%0d q=0x%02h r=0x%02h busy=%0d", state8, q8, r8, busy8);
    chk("rst_mid_state", state8, 0);
    chk("rst_mid_q", q8, 0);
    chk("rst_mid_r", r8, 0);
    chk("rst_mid_flags", {busy8, done8, dbz8, ovf8}, 0);
    @(posedge clk); #1;
    rst = 0;
    run(8, 0, 255, 16, q, r, dz, ov, lat, pulse_ok, busy_ok);
    $display("post-reset 255/16: q=0x%02h r=0x%02h lat=%0d", q, r, lat);
    chk("post_rst_q", q, 15);
    chk("post_rst_r", r, 15);
    chk("post_rst_lat", lat, 18);

    // random sweep against the reference model
    for (int w = 8; w <= 16; w += 8) begin
      for (int i = 0; i < 40; i++) begin
        longint a, b;
        bit s;
        s = i[0];
        a = longint'($urandom_range(0, (1 << w) - 1));
        b = (i % 10 == 9) ? 0 : longint'($urandom_range(0, (1 << w) - 1));
        if (i == 5) begin a = longint'(1) << (w - 1); b = (longint'(1) << w) - 1; end
        model(w, s, a, b, mq, mr, mdz, mov);
        run(w, s, a, b, q, r, dz, ov, lat, pulse_ok, busy_ok);
        $display("sweep w=%0d s=%0d 0x%0h/0x%0h -> q=0x%0h r=0x%0h (model q=0x%0h r=0x%0h)",
                 w, s, a, b, q, r, mq, mr);
        chk("sweep_q", q, mq);
        chk("sweep_r", r, mr);
        chk("sweep_flags", {dz, ov}, {mdz, mov});
        chk("sweep_lat", lat, mdz ? 1 : 2 * w + 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Parametrised multi-cycle restoring divider: datapath and control FSM in one block, with a start/done handshake.
- Supersedes the fixed-width divider control unit.
- Adds generic operand width, runtime signed/unsigned mode, divide-by-zero and overflow flags, and busy/done signalling.
- Sits between the register file and the ALU result mux; one division is in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement truncating division; 0 = unsigned; latched with start
- dividend  input  WIDTH  latched when start is accepted
- divisor  input  WIDTH  latched when start is accepted
- quotient  output  WIDTH  result; held until next accepted start
- remainder  output  WIDTH  result; held until next accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in DONE
- dbz  output  1  divide-by-zero flag; valid with done, held
- ovf  output  1  signed overflow flag; valid with done, held
- state  output  3  FSM state code, for debug

Behaviour:
- Reset (asynchronous, any state including mid-operation):
  - state=IDLE, counter=0.
  - quotient, remainder, busy, done, dbz, ovf all 0.
  - Internal R/Q/D registers cleared.
- State encoding: IDLE=0, SHIFT=1, SUB=2, FIX=3, DONE=4. Codes 5..7 go to IDLE on the next edge.
- IDLE:
  - start=0: stay in IDLE.
  - start=1, divisor=0: go to DONE with dbz=1, ovf=0, quotient = all ones, remainder = dividend (raw bits, both modes).
  - start=1, divisor≠0: clear dbz/ovf and counter, latch is_signed and the operand signs.
    - Load Q with |dividend| and D with |divisor|; magnitudes only when is_signed=1, otherwise raw values.
    - Load R (WIDTH+1 bits) with 0. Go to SHIFT.
- SHIFT: {R,Q} shifted left by 1; go to SUB.
- SUB:
  - t = R − {0,D}, computed at WIDTH+1 bits.
  - t MSB=0: R<=t and Q[0]<=1. Otherwise R unchanged and Q[0]<=0.
  - Counter increments. If counter==WIDTH−1 go to FIX, else go to SHIFT.
- FIX:
  - Unsigned: quotient<=Q, remainder<=R[WIDTH−1:0].
  - Signed: quotient is negated when the operand signs differ; remainder takes the dividend's sign (negated when dividend<0).
  - ovf=1 only when signed, dividend=most-negative and divisor=−1. In that case quotient=most-negative (wrapped) and remainder=0.
  - Go to DONE.
- DONE: done=1 for this single cycle; go to IDLE. Outputs hold until the next accepted start.
- Latency:
  - Normal division: done is high in the cycle beginning 2*WIDTH+2 edges after the edge that samples start (WIDTH=8 gives edge 18).
  - Divide-by-zero: done is high in the cycle after start is sampled.
- start while busy=1 is ignored. Operand changes while busy have no effect.
- start high in the DONE cycle is ignored. start held high into IDLE begins a new division.
- Most-negative magnitude: |x| is computed at WIDTH bits. The most-negative value maps to 2^(WIDTH−1) unsigned, which the algorithm handles correctly.

Test Plan:
- WIDTH=8, unsigned, 100/7 -> quotient=14 (0x0E), remainder=2; done pulses exactly one cycle, 18 edges after start; busy high throughout.
- Signed, −100/7 (0x9C/0x07) -> quotient=0xF2 (−14), remainder=0xFE (−2), ovf=0; and 100/−7 -> quotient=0xF2, remainder=0x02.
- Divisor=0, dividend=0x5A, either mode -> done on the next cycle, dbz=1, quotient=0xFF, remainder=0x5A; a following 9/3 clears dbz and gives quotient=3, remainder=0.
- Signed −128/−1 (0x80/0xFF) -> quotient=0x80, remainder=0, ovf=1; unsigned 0x80/0xFF -> quotient=0, remainder=0x80, ovf=0.
- Pulse start with new operands during busy -> ignored, result of the first operation intact; assert rst mid-SUB -> immediate IDLE with all outputs 0, and a subsequent 255/16 unsigned gives quotient=15, remainder=15.
- Sweep: random operands for WIDTH=8 and WIDTH=16, both modes, checked against a reference model (truncating semantics).
